antares_gpr_sequencer: RTL
==========================

Name: antares_gpr_sequencer

Overview:
Owns the write port and read port A of the GPR file. The GPR file has no reset, so after reset this block first clears registers 1..31. It then passes the pipeline's write-port and port-A traffic straight through. It also serves a debug req/ack handshake, so an external debugger can read or write any GPR while the pipeline is stalled.

Parameters:
INIT_VALUE, 32'h0000_0000, value written to r1..r31 during the init sweep

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
pipe_ra_a  input  5  pipeline port-A read address
pipe_wa  input  5  pipeline write address
pipe_wd  input  32  pipeline write data
pipe_we  input  1  pipeline write enable
gpr_ra_a  output  5  port-A read address to GPR file
gpr_rd_a  input  32  port-A read data from GPR file (combinational)
gpr_wa  output  5  write address to GPR file
gpr_wd  output  32  write data to GPR file
gpr_we  output  1  write enable to GPR file
seq_stall  output  1  pipeline must hold; pipe_* writes are not forwarded
init_done  output  1  high once the init sweep has completed
dbg_req  input  1  debug access request (4-phase)
dbg_we  input  1  1 = write, 0 = read; sampled at acceptance
dbg_addr  input  5  debug GPR address; sampled at acceptance
dbg_wdata  input  32  debug write data; sampled at acceptance
dbg_rdata  output  32  debug read data, registered
dbg_ack  output  1  one-cycle access-complete strobe

Behaviour:
- States: INIT, IDLE, DBG_ACC, DBG_ACK, DBG_WAIT. There is a 5-bit counter init_cnt and latched registers d_we, d_addr, d_wdata.
- Reset (rst_n low, asynchronous):
  - Registers: state=INIT, init_cnt=1, init_done=0, dbg_rdata=0, dbg_ack=0.
  - Outputs: gpr_we is forced 0 while rst_n is low; seq_stall=1.
- INIT:
  - Drives gpr_we=1, gpr_wa=init_cnt, gpr_wd=INIT_VALUE, seq_stall=1.
  - init_cnt increments each cycle.
  - After writing address 31 (exactly 31 write cycles), go to IDLE; init_done=1 from the next cycle onward.
  - pipe_we is ignored. dbg_req is ignored and stays pending.
- IDLE:
  - Pass-through: gpr_wa=pipe_wa, gpr_wd=pipe_wd, gpr_we=pipe_we, gpr_ra_a=pipe_ra_a, seq_stall=0.
  - If dbg_req=1: latch dbg_we, dbg_addr, dbg_wdata and go to DBG_ACC.
  - A pipeline write in the acceptance cycle is still forwarded.
- DBG_ACC (1 cycle, seq_stall=1):
  - Write (d_we=1): gpr_we=1, gpr_wa=d_addr, gpr_wd=d_wdata.
  - Read (d_we=0): gpr_we=0, gpr_ra_a=d_addr; dbg_rdata <= gpr_rd_a at the closing edge.
  - Writes to r0 reach the GPR file, which discards them. Reads of r0 return 0.
  - A write leaves dbg_rdata unchanged.
  - Next state: DBG_ACK.
- DBG_ACK (1 cycle): dbg_ack=1, seq_stall=1; next state DBG_WAIT.
- DBG_WAIT: seq_stall=1, gpr_we=0; stay until dbg_req=0, then go to IDLE.
  - The latency from acceptance edge to dbg_ack is 2 cycles.
  - A new request needs dbg_req to be observed low first.
- gpr_ra_a outside DBG_ACC-read:
  - INIT: 0.
  - IDLE: pipe_ra_a.
  - DBG_ACK and DBG_WAIT: pipe_ra_a.
- seq_stall = 1 in every state except IDLE.
- Reset asserted mid-sweep or mid-debug: state returns to INIT, the sweep restarts at address 1, and a pending debug access is dropped without ack.
- dbg_rdata holds its value until the next debug read completes or until reset.

Test Plan:
1. Release rst_n -> 31 consecutive cycles with gpr_we=1 and gpr_wa=1..31, gpr_wd=0. Then init_done=1, seq_stall=0, and reads of r5 and r31 return 0.
2. IDLE with pipe_we=1, pipe_wa=9, pipe_wd=32'h1234_5678 -> same cycle gpr_we=1, gpr_wa=9, gpr_wd=32'h1234_5678. Then pipe_ra_a=9 gives gpr_rd_a=32'h1234_5678.
3. Debug write r7=32'hDEAD_BEEF, then debug read r7 -> dbg_ack pulses 2 cycles after each acceptance and seq_stall=1 throughout, with dbg_rdata=32'hDEAD_BEEF. A debug write of r0=32'hFFFF_FFFF followed by a debug read of r0 -> dbg_rdata=0.
4. Same cycle: pipe_we=1 (r3, 32'hA5) and dbg_req=1 read r3 -> the pipeline write commits and the debug read returns 32'h0000_00A5.
5. dbg_req held high after ack -> the block stays in DBG_WAIT with seq_stall=1 and no second ack. Dropping dbg_req -> IDLE next cycle.
6. Assert rst_n low at sweep address 15 and release -> the sweep restarts at address 1 and takes 31 cycles. A dbg_req raised during INIT is accepted only after init_done=1.

Source files
------------

// File: rtl/antares_gpr_sequencer.sv
// GPR write-port / read-port-A sequencer: clears r1..r31 after reset, then forwards
// pipeline traffic and serves debugger read/write accesses while the pipeline is stalled.
module antares_gpr_sequencer #(
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  pipe_ra_a,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        pipe_we,
    output logic [4:0]  gpr_ra_a,
    input  logic [31:0] gpr_rd_a,
    output logic [4:0]  gpr_wa,
    output logic [31:0] gpr_wd,
    output logic        gpr_we,
    output logic        seq_stall,
    output logic        init_done,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        DBG_ACC,
        DBG_ACK,
        DBG_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  init_cnt;
    logic        d_we;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata;
    logic        we_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= 5'd1;
            init_done <= 1'b0;
            dbg_rdata <= 32'h0;
            dbg_ack   <= 1'b0;
            d_we      <= 1'b0;
            d_addr    <= 5'd0;
            d_wdata   <= 32'h0;
        end else begin
            state   <= state_nxt;
            dbg_ack <= (state == DBG_ACC);
            if (state == INIT) begin
                init_cnt <= init_cnt + 5'd1;
                if (init_cnt == 5'd31)
                    init_done <= 1'b1;
            end
            if (state == IDLE && dbg_req) begin
                d_we    <= dbg_we;
                d_addr  <= dbg_addr;
                d_wdata <= dbg_wdata;
            end
            if (state == DBG_ACC && !d_we)
                dbg_rdata <= (d_addr == 5'd0) ? 32'h0 : gpr_rd_a;
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        gpr_wa    = pipe_wa;
        gpr_wd    = pipe_wd;
        gpr_ra_a  = pipe_ra_a;
        we_c      = 1'b0;
        seq_stall = 1'b1;
        case (state)
            INIT: begin
                we_c     = 1'b1;
                gpr_wa   = init_cnt;
                gpr_wd   = INIT_VALUE;
                gpr_ra_a = 5'd0;
                if (init_cnt == 5'd31)
                    state_nxt = IDLE;
            end
            IDLE: begin
                seq_stall = 1'b0;
                we_c      = pipe_we;
                if (dbg_req)
                    state_nxt = DBG_ACC;
            end
            DBG_ACC: begin
                if (d_we) begin
                    we_c   = 1'b1;
                    gpr_wa = d_addr;
                    gpr_wd = d_wdata;
                end else begin
                    gpr_ra_a = d_addr;
                end
                state_nxt = DBG_ACK;
            end
            DBG_ACK:  state_nxt = DBG_WAIT;
            DBG_WAIT: if (!dbg_req) state_nxt = IDLE;
            default:  state_nxt = INIT;
        endcase
    end

    // The register file is unreset, so a spurious write while rst_n is low must be blocked here.
    assign gpr_we = we_c & rst_n;

endmodule
